// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the oversampling UART receiver.
// When UART_RX_PARITY_EN is defined, the PARITY state is added to the encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line and received-word signals of the UART receiver.
// When UART_RX_PARITY_EN is defined, parity_err is added.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;

  modport master (output rx, s_tick, input rx_done_tick, dout, frame_err, parity_err);
  modport slave  (input rx, s_tick, output rx_done_tick, dout, frame_err, parity_err);
`else
  modport master (output rx, s_tick, input rx_done_tick, dout, frame_err);
  modport slave  (input rx, s_tick, output rx_done_tick, dout, frame_err);
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops load RESET_VAL while reset_n is low.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start-bit qualification, DBIT data bits, stop check.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  // Tick counter widens beyond 4 bits only when a 1.5/2 stop-bit count needs it.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_START_MID = SW'(START_MID);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic rx_s;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            done_q, done_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_q, par_bit_d;
  logic            perr_q, perr_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.rx),
    .q_o     (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      dout_q    <= '0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    done_d    = 1'b0;
    dout_d    = dout_q;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      // Falling edge is checked every clock so a start bit right after a stop is not missed.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == S_START_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            par_bit_d = rx_s;
            s_d       = '0;
            state_d   = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^b_q) ^ par_bit_q ^ PARITY_ODD;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame (5..9).
REQ-002 SHALL have parameter SB_TICK, default 16: oversample ticks in stop bit (16/24/32 for 1/1.5/2 stop bits).
REQ-003 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx, input, 1: asynchronous serial line; idle high.
REQ-006 SHALL have port s_tick, input, 1: single-cycle 16x-baud enable from the upstream baud-rate counter.
REQ-007 SHALL have port rx_done_tick, output, 1: one-cycle pulse when a frame completes.
REQ-008 SHALL have port dout, output, DBIT: last received data word, LSB = first bit received.
REQ-009 SHALL have port frame_err, output, 1: stop bit sampled low on the last completed frame.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP (PARITY added per REQ-025); tick counter s (4 bits), bit counter n (ceil(log2(DBIT)) bits), shift register b (DBIT bits).
REQ-012 IDLE: rx_s==0 -> START with s=0; evaluated every clk, independent of s_tick.
REQ-013 START: on s_tick with s==7 -> if rx_s==0, DATA with s=0, n=0; if rx_s==1, IDLE (false start, no pulse); else s=s+1 on s_tick.
REQ-014 DATA: on s_tick with s==15 -> b={rx_s, b[DBIT-1:1]}, s=0; if n==DBIT-1 -> STOP (or PARITY), else n=n+1; otherwise s=s+1 on s_tick.
REQ-015 STOP: on s_tick with s==SB_TICK-1 -> IDLE, registered rx_done_tick=1 for exactly the next clk cycle, dout<=b, frame_err<=~rx_s.
REQ-016 SHALL hold all state, counters and outputs in cycles with s_tick==0 (except IDLE detection, REQ-012).
REQ-017 dout and frame_err SHALL hold their values until the next completed frame; a false start SHALL not alter them.
REQ-018 A falling edge of rx_s in the cycle rx_done_tick is high SHALL be detected as the next start bit (back-to-back frames, zero idle gap).
REQ-019 Latency: rx_done_tick SHALL rise one clk after the s_tick at which the final stop-bit count is reached.

Reset
REQ-020 reset_n low SHALL force state IDLE, s=0, n=0, b=0, both synchronizer flops to 1.
REQ-021 reset_n low SHALL force rx_done_tick=0, dout=0, frame_err=0 (and parity_err=0).
REQ-022 Reset asserted mid-frame SHALL abandon the frame; no pulse is generated after release.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL control parity support.
REQ-024 Without UART_RX_PARITY_EN: no parity state, no parity_err port; frame = start + DBIT + stop.
REQ-025 With UART_RX_PARITY_EN: parameter PARITY_ODD (default 0) and output parity_err added; state PARITY between DATA and STOP samples one bit at s==15; parity_err<=(XOR(b)^bit^PARITY_ODD) registered with dout at REQ-015.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state typedef and constants OVERSAMPLE=16, START_MID=7.
REQ-027 Sub-module sync_2ff (reset value parameterised) SHALL implement REQ-010; no other sub-modules.

Verification
REQ-028 Frame 0xA5, 8N1, s_tick every 4 clk (mod-4 counter) -> one rx_done_tick, dout=0xA5, frame_err=0.
REQ-029 rx low for 4 ticks then high -> return to IDLE, no rx_done_tick, dout unchanged.
REQ-030 Frame 0x3C with stop bit driven low -> rx_done_tick, dout=0x3C, frame_err=1; next good frame 0x81 clears frame_err.
REQ-031 Frames 0x00, 0xFF back-to-back with zero idle -> two pulses, dout 0x00 then 0xFF.
REQ-032 reset_n pulsed low during data bit 4 -> no pulse, dout=0; subsequent frame 0x5A received correctly.
REQ-033 With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1.
